id_stage_param: RTL and testbench

- Parametrised next-generation instruction decode stage for the mips_16 core family.
- Holds the instruction register and decodes opcode/fields.
- Reads the register file, resolves BZ/BNZ branches, and emits a registered EX-stage bundle.
- Adds what the fixed 16-bit decoder lacks: valid/ready handshakes on both sides, explicit stall and flush, sticky illegal-opcode flag, and a saturating stall counter.

---
 rtl/mips_16_pkg.sv | 39 +++
 rtl/id_stage_param_if.sv | 53 +++++
 rtl/id_stage_param_decode_ctrl.sv | 53 +++++
 rtl/id_stage_param.sv | 166 ++++++++++++++++
 tb/tb_id_stage_param.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_16_pkg.sv
// Shared opcode and ALU command encodings for the mips_16 decode stage.
// ALU_NC aliases ALU_ADD so that "no command" drives a defined zero value.
package mips_16_pkg;

    localparam int OP_W      = 4;
    localparam int ALU_CMD_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SL   = 4'd6,
        OP_SR   = 4'd7,
        OP_SRU  = 4'd8,
        OP_ADDI = 4'd9,
        OP_LD   = 4'd10,
        OP_ST   = 4'd11,
        OP_BZ   = 4'd12,
        OP_BNZ  = 4'd13
    } op_e;

    localparam logic [ALU_CMD_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_CMD_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_CMD_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_CMD_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_CMD_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_CMD_W-1:0] ALU_SL  = 3'd5;
    localparam logic [ALU_CMD_W-1:0] ALU_SR  = 3'd6;
    localparam logic [ALU_CMD_W-1:0] ALU_SRU = 3'd7;
    localparam logic [ALU_CMD_W-1:0] ALU_NC  = 3'd0;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BZ) || (op == OP_BNZ);
    endfunction

endpackage

// File: rtl/id_stage_param_if.sv
// Decode-stage bus: IF handshake, register-file read ports, hazard/branch
// signals and the registered EX bundle. master = surroundings, slave = stage.
interface id_stage_if
    import mips_16_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 6,
    parameter int CNT_W      = 16
);
    localparam int INSTR_W = OP_W + 2*REG_ADDR_W + IMM_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    instruction;
    logic                  stall;
    logic                  flush;
    logic [REG_ADDR_W-1:0] rf_raddr1;
    logic [REG_ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0]     rf_rdata1;
    logic [DATA_W-1:0]     rf_rdata2;
    logic [REG_ADDR_W-1:0] dec_src1;
    logic [REG_ADDR_W-1:0] dec_src2;
    logic                  branch_taken;
    logic [IMM_W-1:0]      branch_offset;
    logic                  out_valid;
    logic                  out_ready;
    logic [ALU_CMD_W-1:0]  ex_alu_cmd;
    logic [DATA_W-1:0]     ex_src1;
    logic [DATA_W-1:0]     ex_src2;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_sel;
    logic                  illegal_op;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output in_valid, instruction, stall, flush, rf_rdata1, rf_rdata2, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, dec_src1, dec_src2, branch_taken,
               branch_offset, out_valid, ex_alu_cmd, ex_src1, ex_src2, mem_we,
               mem_wdata, wb_en, wb_dest, wb_sel, illegal_op, stall_cnt
    );

    modport slave (
        input  in_valid, instruction, stall, flush, rf_rdata1, rf_rdata2, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, dec_src1, dec_src2, branch_taken,
               branch_offset, out_valid, ex_alu_cmd, ex_src1, ex_src2, mem_we,
               mem_wdata, wb_en, wb_dest, wb_sel, illegal_op, stall_cnt
    );

endinterface

// File: rtl/id_stage_param_decode_ctrl.sv
// Combinational opcode-to-control mapping; unknown opcodes decode as NOP
// with o_illegal raised.
module id_decode_ctrl
    import mips_16_pkg::*;
(
    input  logic [OP_W-1:0]      i_op,
    output logic [ALU_CMD_W-1:0] o_alu_cmd,
    output logic                 o_wb_en,
    output logic                 o_wb_sel,
    output logic                 o_src2_imm_sel,
    output logic                 o_mem_we,
    output logic                 o_illegal
);

    always_comb begin
        o_alu_cmd      = ALU_NC;
        o_wb_en        = 1'b0;
        o_wb_sel       = 1'b0;
        o_src2_imm_sel = 1'b0;
        o_mem_we       = 1'b0;
        o_illegal      = 1'b0;
        case (i_op)
            OP_NOP:  ;
            OP_ADD:  begin o_alu_cmd = ALU_ADD; o_wb_en = 1'b1; end
            OP_SUB:  begin o_alu_cmd = ALU_SUB; o_wb_en = 1'b1; end
            OP_AND:  begin o_alu_cmd = ALU_AND; o_wb_en = 1'b1; end
            OP_OR:   begin o_alu_cmd = ALU_OR;  o_wb_en = 1'b1; end
            OP_XOR:  begin o_alu_cmd = ALU_XOR; o_wb_en = 1'b1; end
            OP_SL:   begin o_alu_cmd = ALU_SL;  o_wb_en = 1'b1; end
            OP_SR:   begin o_alu_cmd = ALU_SR;  o_wb_en = 1'b1; end
            OP_SRU:  begin o_alu_cmd = ALU_SRU; o_wb_en = 1'b1; end
            OP_ADDI: begin
                o_alu_cmd      = ALU_ADD;
                o_wb_en        = 1'b1;
                o_src2_imm_sel = 1'b1;
            end
            OP_LD:   begin
                o_alu_cmd      = ALU_ADD;
                o_wb_en        = 1'b1;
                o_wb_sel       = 1'b1;
                o_src2_imm_sel = 1'b1;
            end
            OP_ST:   begin
                o_alu_cmd      = ALU_ADD;
                o_mem_we       = 1'b1;
                o_src2_imm_sel = 1'b1;
            end
            OP_BZ, OP_BNZ: o_src2_imm_sel = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_param.sv
// Parametrised mips_16 decode stage: instruction register, register-file
// read, branch resolution and a registered EX bundle with valid/ready on both sides.
module id_stage_param
    import mips_16_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 6,   // must be >= REG_ADDR_W and < DATA_W
    parameter int CNT_W      = 16
)(
    input  logic     clk,
    input  logic     rst_n,
    id_stage_if.slave bus
);
    localparam int INSTR_W = OP_W + 2*REG_ADDR_W + IMM_W;

    typedef struct packed {
        logic [ALU_CMD_W-1:0]  alu_cmd;
        logic [DATA_W-1:0]     src1;
        logic [DATA_W-1:0]     src2;
        logic                  mem_we;
        logic [DATA_W-1:0]     mem_wdata;
        logic                  wb_en;
        logic [REG_ADDR_W-1:0] wb_dest;
        logic                  wb_sel;
    } ex_bundle_t;

    logic [INSTR_W-1:0] r_ir;
    logic               r_ir_valid;
    logic               r_out_valid;
    ex_bundle_t         r_bundle;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [OP_W-1:0]       w_op;
    logic [REG_ADDR_W-1:0] w_dest;
    logic [REG_ADDR_W-1:0] w_src1;
    logic [REG_ADDR_W-1:0] w_src2;
    logic [REG_ADDR_W-1:0] w_raddr2;
    logic [IMM_W-1:0]      w_imm;
    logic [DATA_W-1:0]     w_imm_sext;
    logic [ALU_CMD_W-1:0]  w_alu_cmd;
    logic                  w_wb_en;
    logic                  w_wb_sel;
    logic                  w_src2_imm_sel;
    logic                  w_mem_we;
    logic                  w_illegal;
    logic                  w_has_operands;
    logic                  w_rs2_used;
    logic                  w_br_cond;
    logic                  w_advance;
    logic                  w_capture;
    ex_bundle_t            w_bundle;

    assign w_op   = r_ir[INSTR_W-1 -: OP_W];
    assign w_dest = r_ir[2*REG_ADDR_W+IMM_W-1 -: REG_ADDR_W];
    assign w_src1 = r_ir[REG_ADDR_W+IMM_W-1 -: REG_ADDR_W];
    assign w_imm  = r_ir[IMM_W-1:0];
    assign w_src2 = w_imm[IMM_W-1 -: REG_ADDR_W];

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sext
        if (gi < IMM_W) begin : g_low
            assign w_imm_sext[gi] = w_imm[gi];
        end else begin : g_high
            assign w_imm_sext[gi] = w_imm[IMM_W-1];
        end
    end

    id_decode_ctrl u_ctrl (
        .i_op          (w_op),
        .o_alu_cmd     (w_alu_cmd),
        .o_wb_en       (w_wb_en),
        .o_wb_sel      (w_wb_sel),
        .o_src2_imm_sel(w_src2_imm_sel),
        .o_mem_we      (w_mem_we),
        .o_illegal     (w_illegal)
    );

    // Stores read their data register through port 2 via the dest field.
    assign w_raddr2       = (w_op == OP_ST) ? w_dest : w_src2;
    assign w_has_operands = (w_op != OP_NOP) & ~w_illegal;
    assign w_rs2_used     = (w_wb_en & ~w_src2_imm_sel) | w_mem_we;

    assign w_advance = r_ir_valid & ~bus.stall & (~r_out_valid | bus.out_ready);
    assign w_capture = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = ~bus.flush & (~r_ir_valid | w_advance);
    assign bus.rf_raddr1 = r_ir_valid ? w_src1 : '0;
    assign bus.rf_raddr2 = r_ir_valid ? w_raddr2 : '0;
    assign bus.dec_src1  = r_ir_valid ? w_src1 : '0;
    assign bus.dec_src2  = (r_ir_valid & w_rs2_used) ? w_raddr2 : '0;

    assign w_br_cond = (w_op == OP_BZ)  ? (bus.rf_rdata1 == '0) :
                       (w_op == OP_BNZ) ? (bus.rf_rdata1 != '0) : 1'b0;
    assign bus.branch_taken  = w_advance & ~bus.flush & is_branch(w_op) & w_br_cond;
    assign bus.branch_offset = w_imm;

    always_comb begin
        w_bundle         = '0;
        w_bundle.alu_cmd = w_alu_cmd;
        if (w_has_operands) begin
            w_bundle.src1      = bus.rf_rdata1;
            w_bundle.src2      = w_src2_imm_sel ? w_imm_sext : bus.rf_rdata2;
            w_bundle.mem_we    = w_mem_we;
            w_bundle.mem_wdata = w_mem_we ? bus.rf_rdata2 : '0;
            w_bundle.wb_en     = w_wb_en;
            w_bundle.wb_dest   = w_wb_en ? w_dest : '0;
            w_bundle.wb_sel    = w_wb_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (bus.flush) begin
            r_ir_valid <= 1'b0;
        end else if (w_capture) begin
            r_ir       <= bus.instruction;
            r_ir_valid <= 1'b1;
        end else if (w_advance) begin
            r_ir_valid <= 1'b0;
        end
    end

    // A drained output shows a bubble; the bundle fields simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_bundle;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_advance & ~bus.flush & w_illegal)
                r_illegal <= 1'b1;
            if (bus.stall & r_ir_valid & ~(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.ex_alu_cmd = r_bundle.alu_cmd;
    assign bus.ex_src1    = r_bundle.src1;
    assign bus.ex_src2    = r_bundle.src2;
    assign bus.mem_we     = r_bundle.mem_we;
    assign bus.mem_wdata  = r_bundle.mem_wdata;
    assign bus.wb_en      = r_bundle.wb_en;
    assign bus.wb_dest    = r_bundle.wb_dest;
    assign bus.wb_sel     = r_bundle.wb_sel;
    assign bus.illegal_op = r_illegal;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: decode bundles, stall/backpressure,
// branches, flush, illegal opcode and asynchronous reset.
module tb_id_stage_param;
    import mips_16_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(16), .REG_ADDR_W(3), .IMM_W(6), .CNT_W(16)) bus ();

    id_stage_param #(.DATA_W(16), .REG_ADDR_W(3), .IMM_W(6), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [15:0] rf_val(input logic [2:0] a);
        case (a)
            3'd0:    return 16'h0000;
            3'd1:    return 16'h0011;
            3'd2:    return 16'h0005;
            3'd3:    return 16'h0007;
            3'd4:    return 16'h0044;
            3'd5:    return 16'h0055;
            3'd6:    return 16'h0066;
            default: return 16'h0077;
        endcase
    endfunction

    assign bus.rf_rdata1 = rf_val(bus.rf_raddr1);
    assign bus.rf_rdata2 = rf_val(bus.rf_raddr2);

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [5:0] imm);
        return {op, d, s1, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins);
        bus.in_valid    = 1'b1;
        bus.instruction = ins;
        step();
        bus.in_valid = 1'b0;
        $display("txn issue instr=%04h t=%0t", ins, $time);
    endtask

    initial begin
        int idx;
        int rcv;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_illegal", bus.illegal_op, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_ex_src1", bus.ex_src1, 0);
        rst_n = 1'b1;
        step();

        // ADD r1,r2,r3
        issue(enc(OP_ADD, 3'd1, 3'd2, 6'b011000));
        chk("add_dec_src1", bus.dec_src1, 2);
        chk("add_dec_src2", bus.dec_src2, 3);
        step();
        chk("add_out_valid", bus.out_valid, 1);
        chk("add_alu", bus.ex_alu_cmd, ALU_ADD);
        chk("add_src1", bus.ex_src1, 5);
        chk("add_src2", bus.ex_src2, 7);
        chk("add_wb_en", bus.wb_en, 1);
        chk("add_wb_dest", bus.wb_dest, 1);
        chk("add_wb_sel", bus.wb_sel, 0);

        // ADDI r2,r1,-2
        issue(enc(OP_ADDI, 3'd2, 3'd1, 6'b111110));
        chk("addi_dec_src2", bus.dec_src2, 0);
        step();
        chk("addi_src2", bus.ex_src2, 16'hFFFE);
        chk("addi_src1", bus.ex_src1, 16'h0011);
        chk("addi_wb_dest", bus.wb_dest, 2);

        // LD r3,2(r4)
        issue(enc(OP_LD, 3'd3, 3'd4, 6'd2));
        step();
        chk("ld_wb_sel", bus.wb_sel, 1);
        chk("ld_wb_en", bus.wb_en, 1);
        chk("ld_src1", bus.ex_src1, 16'h0044);
        chk("ld_src2", bus.ex_src2, 2);

        // ST r4,1(r5)
        issue(enc(OP_ST, 3'd4, 3'd5, 6'd1));
        chk("st_raddr2", bus.rf_raddr2, 4);
        chk("st_dec_src2", bus.dec_src2, 4);
        step();
        chk("st_mem_we", bus.mem_we, 1);
        chk("st_wb_en", bus.wb_en, 0);
        chk("st_wdata", bus.mem_wdata, 16'h0044);
        chk("st_src1", bus.ex_src1, 16'h0055);
        chk("st_src2", bus.ex_src2, 1);

        // AND r7 then SUB r6 held by a 3-cycle stall
        bus.in_valid    = 1'b1;
        bus.instruction = enc(OP_AND, 3'd7, 3'd2, 6'b011000);
        step();
        bus.instruction = enc(OP_SUB, 3'd6, 3'd2, 6'b011000);
        step();
        bus.in_valid = 1'b0;
        bus.stall    = 1'b1;
        #1;
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_drain_alu", bus.ex_alu_cmd, ALU_AND);
        chk("stall_drain_valid", bus.out_valid, 1);
        step();
        chk("stall_bubble", bus.out_valid, 0);
        step();
        step();
        chk("stall_cnt", bus.stall_cnt, 3);
        chk("stall_bubble2", bus.out_valid, 0);
        bus.stall = 1'b0;
        step();
        $display("txn stall release t=%0t", $time);
        chk("stall_rel_valid", bus.out_valid, 1);
        chk("stall_rel_alu", bus.ex_alu_cmd, ALU_SUB);
        chk("stall_rel_dest", bus.wb_dest, 6);
        chk("stall_cnt_hold", bus.stall_cnt, 3);
        step();

        // 8-deep ADDI stream with 2 cycles of backpressure
        idx = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            bus.in_valid    = (idx < 8);
            bus.instruction = enc(OP_ADDI, idx[2:0], 3'd1, 6'(idx));
            bus.out_ready   = !(cyc == 3 || cyc == 4);
            #1;
            if (!bus.out_ready) begin
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_valid", bus.out_valid, 1);
                chk("bp_hold", bus.ex_src2, rcv);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_src2", bus.ex_src2, rcv);
                chk("stream_dest", bus.wb_dest, rcv & 7);
                $display("txn stream out=%0d t=%0t", rcv, $time);
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", rcv, 8);
        step();

        // Branches
        issue(enc(OP_BZ, 3'd5, 3'd0, 6'd5));
        chk("bz_taken", bus.branch_taken, 1);
        chk("bz_offset", bus.branch_offset, 5);
        step();
        chk("bz_after", bus.branch_taken, 0);
        chk("bz_out_valid", bus.out_valid, 1);
        chk("bz_wb_en", bus.wb_en, 0);
        chk("bz_wb_dest", bus.wb_dest, 0);
        chk("bz_src2", bus.ex_src2, 5);
        issue(enc(OP_BNZ, 3'd0, 3'd0, 6'd3));
        chk("bnz0_taken", bus.branch_taken, 0);
        step();
        issue(enc(OP_BNZ, 3'd0, 3'd2, 6'd3));
        chk("bnz5_taken", bus.branch_taken, 1);
        step();

        // Flush with BZ in the IR and a competing instruction offered
        issue(enc(OP_BZ, 3'd0, 3'd0, 6'd7));
        bus.flush       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.instruction = enc(OP_ADD, 3'd1, 3'd2, 6'b011000);
        #1;
        chk("fl_taken", bus.branch_taken, 0);
        chk("fl_in_ready", bus.in_ready, 0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        $display("txn flush t=%0t", $time);
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_taken_after", bus.branch_taken, 0);
        step();
        chk("fl_no_capture", bus.out_valid, 0);

        // Unknown opcode, stickiness, then async reset mid-stream
        issue(enc(4'hF, 3'd3, 3'd2, 6'd9));
        step();
        chk("ill_out_valid", bus.out_valid, 1);
        chk("ill_wb_en", bus.wb_en, 0);
        chk("ill_mem_we", bus.mem_we, 0);
        chk("ill_alu", bus.ex_alu_cmd, ALU_NC);
        chk("ill_src1", bus.ex_src1, 0);
        chk("ill_flag", bus.illegal_op, 1);
        issue(enc(OP_ADD, 3'd1, 3'd2, 6'b011000));
        step();
        chk("ill_sticky", bus.illegal_op, 1);
        chk("mid_out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn async reset t=%0t", $time);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_illegal", bus.illegal_op, 0);
        chk("arst_wb_en", bus.wb_en, 0);
        chk("arst_src1", bus.ex_src1, 0);
        chk("arst_stall_cnt", bus.stall_cnt, 0);
        #2;
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
